imm_encode: RTL and testbench

IMM_ENCODE -- requirements
Module: imm_encode

---
 rtl/imm_encode.sv | 180 ++++++++++++++++++
 tb/tb_imm_encode.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode.sv
// rtl/imm_encode.sv - two-stage immediate encoder with format/range/alignment checks
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid/in_ready         request handshake (imm, EXTOp)
//   imm[31:0]                 immediate value to encode
//   EXTOp[5:0]                one-hot format: SHAMT,I,S,B,U,J (bit5..bit0)
//   out_valid/out_ready       result handshake
//   iimm_shamt..jimm          packed immediate fields for the selected format
//   instr_imm[31:0]           instruction word with only immediate bits populated
//   err[1:0]                  00 ok, 01 range, 10 misaligned, 11 bad EXTOp
//   err_cnt[7:0]              saturating count of delivered results with err != 00
module imm_encode (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] imm,
    input  logic [5:0]  EXTOp,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  iimm_shamt,
    output logic [11:0] iimm,
    output logic [11:0] simm,
    output logic [11:0] bimm,
    output logic [19:0] uimm,
    output logic [19:0] jimm,
    output logic [31:0] instr_imm,
    output logic [1:0]  err,
    output logic [7:0]  err_cnt
);

    // Stage 1: registered request
    logic        r_s1_valid;
    logic [31:0] r_s1_imm;
    logic [5:0]  r_s1_extop;

    // Stage 2 may load whenever its current content is absent or being consumed.
    logic w_s2_adv;
    assign w_s2_adv = !out_valid || out_ready;
    assign in_ready = !r_s1_valid || w_s2_adv;

    // Encoded result of the stage-1 request
    logic [4:0]  w_shamt;
    logic [11:0] w_iimm;
    logic [11:0] w_simm;
    logic [11:0] w_bimm;
    logic [19:0] w_uimm;
    logic [19:0] w_jimm;
    logic [31:0] w_instr;
    logic [1:0]  w_err;

    logic w_onehot;
    logic w_fit12;   // imm[31:11] all equal: fits a signed 12-bit field
    logic w_fit13;   // imm[31:12] all equal
    logic w_fit21;   // imm[31:20] all equal

    // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit was set.
    assign w_onehot = (r_s1_extop != 6'd0) &&
                      ((r_s1_extop & (r_s1_extop - 6'd1)) == 6'd0);
    assign w_fit12  = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_fit13  = (&r_s1_imm[31:12]) || !(|r_s1_imm[31:12]);
    assign w_fit21  = (&r_s1_imm[31:20]) || !(|r_s1_imm[31:20]);

    always_comb begin
        w_shamt = 5'd0;
        w_iimm  = 12'd0;
        w_simm  = 12'd0;
        w_bimm  = 12'd0;
        w_uimm  = 20'd0;
        w_jimm  = 20'd0;
        w_instr = 32'd0;
        w_err   = 2'b00;
        if (!w_onehot) begin
            w_err = 2'b11;
        end else if (r_s1_extop[5]) begin
            if (r_s1_imm[31:5] != 27'd0) begin
                w_err = 2'b01;
            end else begin
                w_shamt        = r_s1_imm[4:0];
                w_instr[24:20] = r_s1_imm[4:0];
            end
        end else if (r_s1_extop[4]) begin
            if (!w_fit12) begin
                w_err = 2'b01;
            end else begin
                w_iimm         = r_s1_imm[11:0];
                w_instr[31:20] = r_s1_imm[11:0];
            end
        end else if (r_s1_extop[3]) begin
            if (!w_fit12) begin
                w_err = 2'b01;
            end else begin
                w_simm         = r_s1_imm[11:0];
                w_instr[31:25] = r_s1_imm[11:5];
                w_instr[11:7]  = r_s1_imm[4:0];
            end
        end else if (r_s1_extop[2]) begin
            // Misalignment outranks range, so test it first.
            if (r_s1_imm[0]) begin
                w_err = 2'b10;
            end else if (!w_fit13) begin
                w_err = 2'b01;
            end else begin
                w_bimm         = {r_s1_imm[12], r_s1_imm[11], r_s1_imm[10:5], r_s1_imm[4:1]};
                w_instr[31]    = r_s1_imm[12];
                w_instr[7]     = r_s1_imm[11];
                w_instr[30:25] = r_s1_imm[10:5];
                w_instr[11:8]  = r_s1_imm[4:1];
            end
        end else if (r_s1_extop[1]) begin
            if (r_s1_imm[11:0] != 12'd0) begin
                w_err = 2'b01;
            end else begin
                w_uimm         = r_s1_imm[31:12];
                w_instr[31:12] = r_s1_imm[31:12];
            end
        end else begin
            if (r_s1_imm[0]) begin
                w_err = 2'b10;
            end else if (!w_fit21) begin
                w_err = 2'b01;
            end else begin
                w_jimm         = {r_s1_imm[20], r_s1_imm[19:12], r_s1_imm[11], r_s1_imm[10:1]};
                w_instr[31]    = r_s1_imm[20];
                w_instr[30:21] = r_s1_imm[10:1];
                w_instr[20]    = r_s1_imm[11];
                w_instr[19:12] = r_s1_imm[19:12];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid <= 1'b0;
            r_s1_imm   <= 32'd0;
            r_s1_extop <= 6'd0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_imm   <= imm;
                r_s1_extop <= EXTOp;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            iimm_shamt <= 5'd0;
            iimm       <= 12'd0;
            simm       <= 12'd0;
            bimm       <= 12'd0;
            uimm       <= 20'd0;
            jimm       <= 20'd0;
            instr_imm  <= 32'd0;
            err        <= 2'b00;
        end else if (w_s2_adv) begin
            out_valid  <= r_s1_valid;
            iimm_shamt <= w_shamt;
            iimm       <= w_iimm;
            simm       <= w_simm;
            bimm       <= w_bimm;
            uimm       <= w_uimm;
            jimm       <= w_jimm;
            instr_imm  <= w_instr;
            err        <= w_err;
        end
    end

    // Counts against the result currently presented, at the moment it is consumed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= 8'd0;
        end else if (out_valid && out_ready && (err != 2'b00) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_imm_encode.sv
// tb/tb_imm_encode.sv - scoreboard testbench for imm_encode
module tb_imm_encode;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] imm;
    logic [5:0]  EXTOp;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  iimm_shamt;
    logic [11:0] iimm;
    logic [11:0] simm;
    logic [11:0] bimm;
    logic [19:0] uimm;
    logic [19:0] jimm;
    logic [31:0] instr_imm;
    logic [1:0]  err;
    logic [7:0]  err_cnt;

    imm_encode dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm        (imm),
        .EXTOp      (EXTOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .iimm_shamt (iimm_shamt),
        .iimm       (iimm),
        .simm       (simm),
        .bimm       (bimm),
        .uimm       (uimm),
        .jimm       (jimm),
        .instr_imm  (instr_imm),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [11:0] iimm;
        logic [11:0] simm;
        logic [11:0] bimm;
        logic [19:0] uimm;
        logic [19:0] jimm;
        logic [31:0] instr;
        logic [1:0]  err;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   acc_cnt = 0;
    int   delivered = 0;
    int   first_stall = -1;
    bit   bp_watch = 0;
    int   m_cnt = 0;
    logic [31:0] rt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // fld holds the hand-computed packed field for the selected format.
    task automatic send(input logic [5:0] op, input logic [31:0] v,
                        input logic [19:0] fld, input logic [31:0] ins, input logic [1:0] er);
        exp_t e;
        bit   acc;
        int   n;
        e = '0;
        e.op = op; e.imm = v; e.instr = ins; e.err = er;
        if (er == 2'b00) begin
            case (op)
                6'h20:   e.shamt = fld[4:0];
                6'h10:   e.iimm  = fld[11:0];
                6'h08:   e.simm  = fld[11:0];
                6'h04:   e.bimm  = fld[11:0];
                6'h02:   e.uimm  = fld;
                6'h01:   e.jimm  = fld;
                default: ;
            endcase
        end
        in_valid = 1'b1; EXTOp = op; imm = v;
        acc = 0; n = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            else if (bp_watch && first_stall < 0) first_stall = acc_cnt;
            n++;
        end
        if (acc) begin
            sb.push_back(e);
            acc_cnt++;
        end else begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=stalled required=accepted");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            delivered++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output actual=instr %h err %0d required=none", instr_imm, err);
            end else begin
                m_e = sb.pop_front();
                chk("err",        32'(err),        32'(m_e.err));
                chk("instr_imm",  instr_imm,       m_e.instr);
                chk("iimm_shamt", 32'(iimm_shamt), 32'(m_e.shamt));
                chk("iimm",       32'(iimm),       32'(m_e.iimm));
                chk("simm",       32'(simm),       32'(m_e.simm));
                chk("bimm",       32'(bimm),       32'(m_e.bimm));
                chk("uimm",       32'(uimm),       32'(m_e.uimm));
                chk("jimm",       32'(jimm),       32'(m_e.jimm));
                chk("err_cnt",    32'(err_cnt),    32'(m_cnt));
                if (m_e.err != 2'b00 && m_cnt < 255) m_cnt++;
                if (m_e.err == 2'b00) begin
                    case (m_e.op)
                        6'h20:   rt = {27'd0, iimm_shamt};
                        6'h10:   rt = {{20{iimm[11]}}, iimm};
                        6'h08:   rt = {{20{simm[11]}}, simm};
                        6'h04:   rt = {{19{bimm[11]}}, bimm, 1'b0};
                        6'h02:   rt = {uimm, 12'd0};
                        default: rt = {{11{jimm[19]}}, jimm, 1'b0};
                    endcase
                    chk("round_trip", rt, m_e.imm);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; imm = 32'd0; EXTOp = 6'd0; out_ready = 1'b1;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("rst_instr",     instr_imm,      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        #20 rstn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: op, imm, packed field, instr_imm, err
        send(6'h10, 32'hFFFFF800, 20'h00800, 32'h80000000, 2'b00);
        send(6'h04, 32'hFFFFFFFE, 20'h00FFF, 32'hFE000F80, 2'b00);
        send(6'h04, 32'h00000003, 20'h0,     32'h0,        2'b10);
        send(6'h01, 32'h00000800, 20'h00400, 32'h00100000, 2'b00);
        send(6'h02, 32'h12345001, 20'h0,     32'h0,        2'b01);
        send(6'h06, 32'h00000000, 20'h0,     32'h0,        2'b11);
        send(6'h20, 32'h0000001F, 20'h0001F, 32'h01F00000, 2'b00);
        send(6'h20, 32'h00000020, 20'h0,     32'h0,        2'b01);
        send(6'h08, 32'h000007FF, 20'h007FF, 32'h7E000F80, 2'b00);
        send(6'h02, 32'hABCDE000, 20'hABCDE, 32'hABCDE000, 2'b00);
        send(6'h10, 32'h00000800, 20'h0,     32'h0,        2'b01);
        send(6'h01, 32'h00000003, 20'h0,     32'h0,        2'b10);
        send(6'h04, 32'h00001001, 20'h0,     32'h0,        2'b10);
        send(6'h00, 32'h00000000, 20'h0,     32'h0,        2'b11);
        send(6'h01, 32'hFFF00000, 20'h80000, 32'h80000000, 2'b00);
        send(6'h3F, 32'h00000000, 20'h0,     32'h0,        2'b11);
        send(6'h10, 32'h00000123, 20'h00123, 32'h12300000, 2'b00);
        drain();

        // Backpressure: out_ready low for 3 cycles while streaming 4 requests
        @(posedge clk); #1;
        out_ready = 1'b0; acc_cnt = 0; first_stall = -1; bp_watch = 1;
        delivered = 0;
        fork
            begin
                send(6'h10, 32'h00000001, 20'h00001, 32'h00100000, 2'b00);
                send(6'h10, 32'h00000002, 20'h00002, 32'h00200000, 2'b00);
                send(6'h10, 32'h00000003, 20'h00003, 32'h00300000, 2'b00);
                send(6'h10, 32'h00000004, 20'h00004, 32'h00400000, 2'b00);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        bp_watch = 0;
        drain();
        chk("bp_stall_after", 32'(first_stall), 32'd2);
        chk("bp_delivered",   32'(delivered),   32'd4);

        // Reset with 2 requests in flight
        out_ready = 1'b0;
        send(6'h10, 32'h00000005, 20'h00005, 32'h00500000, 2'b00);
        send(6'h10, 32'h00000006, 20'h00006, 32'h00600000, 2'b00);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_err_cnt",   32'(err_cnt),   32'd0);
        chk("mid_rst_in_ready",  32'(in_ready),  32'd1);
        chk("mid_rst_instr",     instr_imm,      32'd0);
        sb.delete();
        m_cnt = 0;
        #13 rstn = 1'b1;
        out_ready = 1'b1;
        delivered = 0;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale_result", 32'(delivered), 32'd0);

        // Saturation of err_cnt
        for (int i = 0; i < 300; i++)
            send(6'h00, 32'(i), 20'h0, 32'h0, 2'b11);
        drain();
        chk("err_cnt_sat", 32'(err_cnt), 32'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
